// File: rtl/edge_event_scheduler_if.sv
// Event handshake between the edge scheduler and its downstream consumer.
// The scheduler drives the event register; the consumer returns ready.
interface edge_event_scheduler_if #(
  parameter int CH_W = 2
);
  logic            valid;
  logic            ready;
  logic [CH_W-1:0] ch;
  logic            fall;

  modport master (output valid, output ch, output fall, input ready);
  modport slave  (input valid, input ch, input fall, output ready);
endinterface

// File: rtl/edge_event_scheduler.sv
// Buffers per-channel rise/fall pulses in pending bits and serialises them onto
// one valid/ready event port through a round-robin arbiter with drop accounting.
module edge_event_scheduler #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          en_mask,
  input  logic [NCH-1:0]          rise_in,
  input  logic [NCH-1:0]          fall_in,
  input  logic                    ovf_clr,
  output logic [NCH-1:0]          ovf_flags,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    busy,
  edge_event_scheduler_if.master  evt
);

  localparam int CH_W  = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;
  // Wide enough to add up to 2*NCH (<= 32) drops without wrapping.
  localparam int SUM_W = CNT_W + 6;

  logic [NCH-1:0]   pend_r, pend_f;
  logic [CH_W-1:0]  rr_ptr;
  logic             evt_valid_q;
  logic [CH_W-1:0]  evt_ch_q;
  logic             evt_fall_q;

  logic             load;
  logic [NCH-1:0]   pend_any;
  logic             found;
  logic [CH_W-1:0]  win;
  logic [CH_W-1:0]  cand;
  int               scan_idx;
  logic [NCH-1:0]   gnt_r, gnt_f;
  logic [NCH-1:0]   drop_r, drop_f;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] drop_cnt_nxt;
  logic [CH_W-1:0]  rr_next;

  assign load     = !evt_valid_q || evt.ready;
  assign pend_any = pend_r | pend_f;

  // Round-robin scan starting at rr_ptr; first channel with anything pending wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    scan_idx = 0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NCH) scan_idx = scan_idx - NCH;
      cand = CH_W'(scan_idx);
      if (!found && pend_any[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Rise is served before fall within the winning channel.
  always_comb begin
    gnt_r = '0;
    gnt_f = '0;
    if (load && found) begin
      if (pend_r[win]) gnt_r[win] = 1'b1;
      else             gnt_f[win] = 1'b1;
    end
  end

  // A pulse onto a bit that stays pending is lost; a grant on the same bit frees it.
  assign drop_r = en_mask & rise_in & pend_r & ~gnt_r;
  assign drop_f = en_mask & fall_in & pend_f & ~gnt_f;

  always_comb begin
    cnt_sum = SUM_W'(drop_cnt) + SUM_W'($countones(drop_r)) + SUM_W'($countones(drop_f));
    if (cnt_sum > SUM_W'({CNT_W{1'b1}})) drop_cnt_nxt = '1;
    else                                 drop_cnt_nxt = cnt_sum[CNT_W-1:0];
  end

  assign rr_next = (win == CH_W'(NCH - 1)) ? '0 : win + CH_W'(1);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r      <= '0;
      pend_f      <= '0;
      ovf_flags   <= '0;
      drop_cnt    <= '0;
      rr_ptr      <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_fall_q  <= 1'b0;
    end else begin
      // Set wins over grant; a disabled channel flushes its pending bits.
      pend_r <= en_mask & ((pend_r & ~gnt_r) | rise_in);
      pend_f <= en_mask & ((pend_f & ~gnt_f) | fall_in);

      if (ovf_clr) begin
        ovf_flags <= '0;
        drop_cnt  <= '0;
      end else begin
        ovf_flags <= ovf_flags | drop_r | drop_f;
        drop_cnt  <= drop_cnt_nxt;
      end

      if (load) begin
        evt_valid_q <= found;
        if (found) begin
          evt_ch_q   <= win;
          evt_fall_q <= !pend_r[win];
          rr_ptr     <= rr_next;
        end
      end
    end
  end

  assign evt.valid = evt_valid_q;
  assign evt.ch    = evt_ch_q;
  assign evt.fall  = evt_fall_q;
  assign busy      = (|pend_r) || (|pend_f) || evt_valid_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed bench for edge_event_scheduler: inputs change and outputs are
// sampled on the falling clock edge, expected values are hand-derived.
module tb_edge_event_scheduler;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;
  localparam int CH_W  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   en_mask;
  logic [NCH-1:0]   rise_in;
  logic [NCH-1:0]   fall_in;
  logic             ovf_clr;
  logic [NCH-1:0]   ovf_flags;
  logic [CNT_W-1:0] drop_cnt;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  edge_event_scheduler_if #(.CH_W(CH_W)) evt_bus ();

  edge_event_scheduler #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_mask   (en_mask),
    .rise_in   (rise_in),
    .fall_in   (fall_in),
    .ovf_clr   (ovf_clr),
    .ovf_flags (ovf_flags),
    .drop_cnt  (drop_cnt),
    .busy      (busy),
    .evt       (evt_bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_evt(input string tag, input logic v, input logic [CH_W-1:0] c, input logic f);
    check({tag, "_valid"}, 32'(evt_bus.valid), 32'(v));
    if (v) begin
      check({tag, "_ch"}, 32'(evt_bus.ch), 32'(c));
      check({tag, "_fall"}, 32'(evt_bus.fall), 32'(f));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(evt_bus.valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_ovf(input string tag, input logic [NCH-1:0] flags, input logic [CNT_W-1:0] cnt);
    check({tag, "_flags"}, 32'(ovf_flags), 32'(flags));
    check({tag, "_cnt"}, 32'(drop_cnt), 32'(cnt));
  endtask

  initial begin
    rst           = 1'b1;
    en_mask       = 4'hF;
    rise_in       = '0;
    fall_in       = '0;
    ovf_clr       = 1'b0;
    evt_bus.ready = 1'b1;

    // Reset, then idle
    tick(); tick();
    check_idle("rst");
    check_ovf("rst", 4'b0000, 8'd0);
    rst = 1'b0;
    tick(); tick();
    check_idle("idle");
    check_ovf("idle", 4'b0000, 8'd0);

    // Single rise on ch2: pending after one edge, presented after the next
    rise_in = 4'b0100;
    tick();
    rise_in = '0;
    check("single_pend_busy", 32'(busy), 32'd1);
    check("single_pend_valid", 32'(evt_bus.valid), 32'd0);
    tick();
    check_evt("single", 1'b1, 2'd2, 1'b0);
    tick();
    check_idle("single_done");

    // Round robin from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rise_in = 4'b1111;
    tick();
    rise_in = '0;
    tick(); check_evt("rr0", 1'b1, 2'd0, 1'b0);
    tick(); check_evt("rr1", 1'b1, 2'd1, 1'b0);
    tick(); check_evt("rr2", 1'b1, 2'd2, 1'b0);
    tick(); check_evt("rr3", 1'b1, 2'd3, 1'b0);
    rise_in = 4'b1001;
    tick();
    rise_in = '0;
    check_evt("rr_gap", 1'b0, 2'd0, 1'b0);
    tick(); check_evt("rrw0", 1'b1, 2'd0, 1'b0);
    tick(); check_evt("rrw3", 1'b1, 2'd3, 1'b0);
    tick(); check_idle("rr_done");

    // Backpressure with rise then fall on ch1
    evt_bus.ready = 1'b0;
    rise_in = 4'b0010;
    tick();
    rise_in = '0;
    tick();
    check_evt("bp_load", 1'b1, 2'd1, 1'b0);
    fall_in = 4'b0010;
    tick();
    fall_in = '0;
    check_evt("bp_hold1", 1'b1, 2'd1, 1'b0);
    tick();
    check_evt("bp_hold2", 1'b1, 2'd1, 1'b0);
    check("bp_busy", 32'(busy), 32'd1);
    evt_bus.ready = 1'b1;
    tick();
    check_evt("bp_fall", 1'b1, 2'd1, 1'b1);
    tick();
    check_idle("bp_done");

    // Overflow on ch0 while the register is stalled (rr_ptr now 2)
    evt_bus.ready = 1'b0;
    rise_in = 4'b0001;
    tick();
    rise_in = '0;
    tick();
    rise_in = 4'b0001;
    tick();
    rise_in = '0;
    check_ovf("ovf_none", 4'b0000, 8'd0);
    tick();
    rise_in = 4'b0001;
    tick();
    rise_in = '0;
    check_ovf("ovf_one", 4'b0001, 8'd1);
    check_evt("ovf_held", 1'b1, 2'd0, 1'b0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_ovf("ovf_clr", 4'b0000, 8'd0);
    rise_in = 4'b0001;
    ovf_clr = 1'b1;
    tick();
    rise_in = '0;
    ovf_clr = 1'b0;
    check_ovf("clr_wins", 4'b0000, 8'd0);
    rise_in = 4'b0110;
    tick();
    rise_in = 4'b0111;
    tick();
    rise_in = '0;
    check_ovf("multi_drop", 4'b0111, 8'd3);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_ovf("multi_clr", 4'b0000, 8'd0);

    // Saturation: three drops per cycle
    rise_in = 4'b0111;
    repeat (84) tick();
    check_ovf("sat_252", 4'b0111, 8'd252);
    repeat (16) tick();
    rise_in = '0;
    check_ovf("sat_255", 4'b0111, 8'd255);

    // Disable ch2 while pending; rr_ptr is 1 so ch1 then ch0, never ch2
    en_mask = 4'b1011;
    evt_bus.ready = 1'b1;
    tick(); check_evt("dis_a", 1'b1, 2'd1, 1'b0);
    tick(); check_evt("dis_b", 1'b1, 2'd0, 1'b0);
    tick(); check_idle("dis_done");
    tick(); check_idle("dis_quiet");
    check_ovf("dis_sticky", 4'b0111, 8'd255);

    // Reset mid-stream
    en_mask = 4'hF;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    evt_bus.ready = 1'b0;
    rise_in = 4'b1111;
    tick();
    rise_in = 4'b0001;
    tick();
    rise_in = '0;
    check_ovf("pre_rst", 4'b0001, 8'd1);
    check_evt("pre_rst", 1'b1, 2'd1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_rst");
    check_ovf("mid_rst", 4'b0000, 8'd0);
    evt_bus.ready = 1'b1;
    rise_in = 4'b1010;
    tick();
    rise_in = '0;
    tick(); check_evt("post_rst_a", 1'b1, 2'd1, 1'b0);
    tick(); check_evt("post_rst_b", 1'b1, 2'd3, 1'b0);
    tick(); check_idle("post_rst_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
